// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types for the PLL reconfiguration control path
package pll_ctrl_pkg;

   localparam int PLL_ADDR_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RDY,
      S_WAIT_LOCK,
      S_SETTLE,
      S_DONE
   } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin winner: first set request bit at or after ptr, wrapping
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   win,
   output logic            any
);

   // Scan offsets from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      win = '0;
      any = |req;
      for (int o = NREQ - 1; o >= 0; o--) begin
         int idx;
         idx = int'(ptr) + o;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) win = IW'(idx);
      end
   end

endmodule

// File: rtl/pll_cfg_arb.sv
// rtl/pll_cfg_arb.sv - arbitrating sequencer driving pll_drp change requests and
// waiting for the PLL to return to a stable lock
module pll_cfg_arb
   import pll_ctrl_pkg::*;
#(
   parameter int             NREQ    = 2,
   parameter int             TOW     = 16,
   parameter logic [TOW-1:0] TIMEOUT = 16'hFFFF,
   parameter logic [7:0]     SETTLE  = 8'd15
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NREQ-1:0]              REQ,
   input  logic [NREQ*PLL_ADDR_W-1:0]   ADDR,
   output logic [NREQ-1:0]              GNT,
   output logic                         DONE,
   output logic                         ERR,
   output logic                         BUSY,
   output logic [PLL_ADDR_W-1:0]        PLL_ADDR,
   output logic                         PLL_CHG,
   input  logic                         PLL_SRDY,
   input  logic                         PLL_LOCK
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e                state_q, state_d;
   logic [IW-1:0]         win_q, win_d, ptr_q, ptr_d, pick;
   logic                  any;
   logic [PLL_ADDR_W-1:0] addr_q, addr_d;
   logic [TOW-1:0]        tmr_q, tmr_d, tmr_sat;
   logic [7:0]            cnt_q, cnt_d, cnt_inc;
   logic                  to_q, to_d;
   logic                  lock_m_q, lock_m_d, lock_s_q, lock_s_d;

   logic [NREQ-1:0]       gnt_q, gnt_d;
   logic                  done_q, done_d, err_q, err_d, busy_q, busy_d, chg_q, chg_d;
   logic [PLL_ADDR_W-1:0] pll_addr_q, pll_addr_d;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
      .req (REQ),
      .ptr (ptr_q),
      .win (pick),
      .any (any)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         win_q      <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         tmr_q      <= '0;
         cnt_q      <= '0;
         to_q       <= 1'b0;
         lock_m_q   <= 1'b0;
         lock_s_q   <= 1'b0;
         gnt_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         chg_q      <= 1'b0;
         pll_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         tmr_q      <= tmr_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         lock_m_q   <= lock_m_d;
         lock_s_q   <= lock_s_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         chg_q      <= chg_d;
         pll_addr_q <= pll_addr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      tmr_d    = tmr_q;
      cnt_d    = cnt_q;
      to_d     = to_q;
      lock_m_d = PLL_LOCK;
      lock_s_d = lock_m_q;
      tmr_sat  = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
      cnt_inc  = cnt_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (any) begin
               state_d = S_ISSUE;
               win_d   = pick;
               addr_d  = ADDR[int'(pick)*PLL_ADDR_W +: PLL_ADDR_W];
            end
         end
         S_ISSUE: begin
            tmr_d   = '0;
            cnt_d   = '0;
            to_d    = 1'b0;
            state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (PLL_SRDY) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = S_SETTLE;
               cnt_d   = 8'd1;
            end
         end
         S_SETTLE: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= SETTLE) state_d = S_DONE;
            end
         end
         S_DONE: begin
            ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Timeout takes priority over whatever the state decode chose this cycle.
      if (state_q inside {S_WAIT_RDY, S_WAIT_LOCK, S_SETTLE}) begin
         tmr_d = tmr_sat;
         if (tmr_sat == TIMEOUT) begin
            state_d = S_DONE;
            to_d    = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_d = '0;
      if (state_q != S_IDLE) gnt_d[win_q] = 1'b1;
      done_d     = (state_q == S_DONE);
      err_d      = (state_q == S_DONE) && to_q;
      chg_d      = (state_q == S_ISSUE);
      busy_d     = (state_d != S_IDLE);
      pll_addr_d = (state_q == S_ISSUE) ? addr_q : pll_addr_q;
   end

   assign GNT      = gnt_q;
   assign DONE     = done_q;
   assign ERR      = err_q;
   assign BUSY     = busy_q;
   assign PLL_ADDR = pll_addr_q;
   assign PLL_CHG  = chg_q;

endmodule

// File: tb/tb_pll_cfg_arb.sv
// tb/tb_pll_cfg_arb.sv - directed self-checking bench for pll_cfg_arb
module tb_pll_cfg_arb;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [1:0]  REQ = 2'b00;
   logic [15:0] ADDR = {8'hB2, 8'h23};
   logic [1:0]  GNT;
   logic        DONE, ERR, BUSY, PLL_CHG;
   logic [7:0]  PLL_ADDR;
   logic        PLL_SRDY = 1'b0;
   logic        PLL_LOCK = 1'b0;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int chg_cnt = 0;

   pll_cfg_arb #(.NREQ(2), .TOW(16), .TIMEOUT(16'd100), .SETTLE(8'd15)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .ADDR     (ADDR),
      .GNT      (GNT),
      .DONE     (DONE),
      .ERR      (ERR),
      .BUSY     (BUSY),
      .PLL_ADDR (PLL_ADDR),
      .PLL_CHG  (PLL_CHG),
      .PLL_SRDY (PLL_SRDY),
      .PLL_LOCK (PLL_LOCK)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (DONE === 1'b1) done_cnt++;
      if (PLL_CHG === 1'b1) chg_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_gnt();
      for (int i = 0; i < 10; i++) begin
         if (GNT !== 2'b00) break;
         step();
      end
   endtask

   // Undisturbed lock: DONE 18 edges after LOCK is driven (2 sync + 16); glitch adds 8.
   task automatic run_one(input string tag, input logic [1:0] exp_gnt, input logic [7:0] exp_addr,
                          input bit glitch, input bit drop_mid, input bit drop_done);
      int n;
      wait_gnt();
      chk({tag, "_gnt"}, GNT, exp_gnt);
      chk({tag, "_addr"}, PLL_ADDR, exp_addr);
      chk({tag, "_chg_hi"}, PLL_CHG, 1);
      step();
      chk({tag, "_chg_lo"}, PLL_CHG, 0);
      chk({tag, "_busy"}, BUSY, 1);
      repeat (8) step();
      PLL_SRDY = 1'b1;
      step();
      PLL_SRDY = 1'b0;
      if (drop_mid) REQ = 2'b00;
      step();
      PLL_LOCK = 1'b1;
      n = 0;
      while (n < 60 && DONE !== 1'b1) begin
         step();
         n++;
         if (glitch && n == 7) PLL_LOCK = 1'b0;
         if (glitch && n == 8) PLL_LOCK = 1'b1;
      end
      chk({tag, "_done_lat"}, n, glitch ? 26 : 18);
      chk({tag, "_err"}, ERR, 0);
      chk({tag, "_gnt_done"}, GNT, exp_gnt);
      if (drop_done) REQ = 2'b00;
      PLL_LOCK = 1'b0;
      step();
      chk({tag, "_gnt_rel"}, GNT, 0);
      chk({tag, "_done_pulse"}, DONE, 0);
   endtask

   initial begin
      int n;
      repeat (3) step();
      chk("rst_gnt", GNT, 0);
      chk("rst_done", DONE, 0);
      chk("rst_err", ERR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_addr", PLL_ADDR, 0);
      chk("rst_chg", PLL_CHG, 0);
      RST = 1'b0;
      step();

      // single request from requester 0
      REQ = 2'b01;
      step();
      chk("single_no_gnt_yet", GNT, 0);
      chk("single_no_chg_yet", PLL_CHG, 0);
      run_one("single", 2'b01, 8'h23, 0, 0, 1);

      // stray SRDY while idle, then REQ dropped while waiting for lock
      PLL_SRDY = 1'b1;
      step();
      PLL_SRDY = 1'b0;
      step();
      chk("stray_busy", BUSY, 0);
      chk("stray_gnt", GNT, 0);
      chk("stray_chg", PLL_CHG, 0);
      REQ = 2'b10;
      run_one("drop_mid", 2'b10, 8'hB2, 0, 1, 0);

      // contention: both held, pointer is back at 0
      REQ = 2'b11;
      run_one("rr0", 2'b01, 8'h23, 0, 0, 0);
      run_one("rr1", 2'b10, 8'hB2, 0, 0, 0);
      run_one("rr2", 2'b01, 8'h23, 0, 0, 0);
      run_one("rr3", 2'b10, 8'hB2, 0, 0, 1);

      // lock glitch at settle count 7
      REQ = 2'b01;
      run_one("glitch", 2'b01, 8'h23, 1, 0, 1);

      // timeout: SRDY never comes, DONE/ERR 101 edges after the CHG cycle
      REQ = 2'b10;
      wait_gnt();
      chk("to_gnt", GNT, 2'b10);
      chk("to_addr", PLL_ADDR, 8'hB2);
      n = 0;
      while (n < 150 && DONE !== 1'b1) begin
         step();
         n++;
      end
      chk("to_lat", n, 101);
      chk("to_err", ERR, 1);
      chk("to_gnt_done", GNT, 2'b10);
      REQ = 2'b00;
      step();
      chk("to_gnt_rel", GNT, 0);
      chk("to_err_clr", ERR, 0);

      // reset in the middle of SETTLE
      REQ = 2'b01;
      wait_gnt();
      chk("mid_gnt", GNT, 2'b01);
      repeat (8) step();
      PLL_SRDY = 1'b1;
      step();
      PLL_SRDY = 1'b0;
      step();
      PLL_LOCK = 1'b1;
      repeat (10) step();
      chk("mid_busy_pre", BUSY, 1);
      #2;
      RST = 1'b1;
      #1;
      chk("mid_rst_gnt", GNT, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_addr", PLL_ADDR, 0);
      chk("mid_rst_done", DONE, 0);
      chk("mid_rst_chg", PLL_CHG, 0);
      REQ = 2'b10;
      PLL_LOCK = 1'b0;
      step();
      step();
      RST = 1'b0;
      run_one("post_rst", 2'b10, 8'hB2, 0, 0, 1);

      chk("done_count", done_cnt, 9);
      chk("chg_count", chg_cnt, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

endmodule
